// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like arbiter: response source tags and arbiter FSM encodings.
package sram_like_arbiter_pkg;

  localparam logic SRAM_TAG_INST = 1'b0;
  localparam logic SRAM_TAG_DATA = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_tag_fifo.sv
// DEPTH x 1-bit FIFO holding the source tag of each accepted, still-unanswered request.
module sram_tag_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       din_i,
  output logic                       dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          mem_q [DEPTH];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave port between instruction and data masters; data wins unless
// instruction has waited DATA_STREAK grants, and a tag FIFO routes in-order responses back.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4,
  parameter int DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic [31:0] inst_addr_ok_addr,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic [31:0] s_addr_ok_addr,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        err_unexp_rsp
);

  localparam int SW = $clog2(DATA_STREAK + 1);
  localparam int CW = $clog2(OUTSTANDING) + 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          err_q, err_d;
  logic          grant_inst, grant_data, accept;
  logic          fifo_full, fifo_empty, fifo_head, fifo_pop;
  logic [CW-1:0] fifo_count;

  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state_q)
      ARB_LOCK_I: grant_inst = 1'b1;
      ARB_LOCK_D: grant_data = 1'b1;
      default: begin
        if (data_req && (streak_q < STREAK_MAX || !inst_req)) grant_data = 1'b1;
        else if (inst_req)                                    grant_inst = 1'b1;
      end
    endcase
  end

  // Reset gates s_req so no addr_ok can be seen while reset is held.
  always_comb begin
    s_req   = ((grant_inst & inst_req) | (grant_data & data_req)) & ~fifo_full & ~reset;
    s_wr    = 1'b0;
    s_size  = '0;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (grant_data) begin
      s_wr = data_wr; s_size = data_size; s_wstrb = data_wstrb;
      s_addr = data_addr; s_wdata = data_wdata;
    end else if (grant_inst) begin
      s_wr = inst_wr; s_size = inst_size; s_wstrb = inst_wstrb;
      s_addr = inst_addr; s_wdata = inst_wdata;
    end
  end

  assign accept       = s_req & s_addr_ok;
  assign inst_addr_ok = accept & grant_inst;
  assign data_addr_ok = accept & grant_data;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (s_req && !s_addr_ok) state_d = grant_data ? ARB_LOCK_D : ARB_LOCK_I;
      ARB_LOCK_I,
      ARB_LOCK_D: if (accept) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (!inst_req || inst_addr_ok)                streak_d = '0;
    else if (data_addr_ok && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
  end

  assign err_d = err_q | (s_data_ok & (fifo_count == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      streak_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      err_q    <= err_d;
    end
  end

  assign fifo_pop = s_data_ok & ~fifo_empty;

  sram_tag_fifo #(.DEPTH(OUTSTANDING)) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (accept),
    .pop_i   (fifo_pop),
    .din_i   (grant_data ? SRAM_TAG_DATA : SRAM_TAG_INST),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign inst_data_ok      = fifo_pop & (fifo_head == SRAM_TAG_INST);
  assign data_data_ok      = fifo_pop & (fifo_head == SRAM_TAG_DATA);
  assign inst_rdata        = s_rdata;
  assign data_rdata        = s_rdata;
  assign inst_addr_ok_addr = s_addr_ok_addr;
  assign err_unexp_rsp     = err_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter: grants, lock, streak, FIFO full, errors, reset.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, s_size;
  logic [3:0]  inst_wstrb, data_wstrb, s_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_addr_ok_addr, inst_rdata, data_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok, err_unexp_rsp;
  logic [31:0] s_addr, s_wdata, s_addr_ok_addr, s_rdata;

  int vecs = 0;
  int errs = 0;

  localparam logic [31:0] IA = 32'hBFC0_0000;
  localparam logic [31:0] DA = 32'h8000_1230;

  sram_like_arbiter #(.OUTSTANDING(4), .DATA_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_addr_ok_addr(inst_addr_ok_addr), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_addr_ok_addr(s_addr_ok_addr),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata), .err_unexp_rsp(err_unexp_rsp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; data_req = 0; s_addr_ok = 0; s_data_ok = 0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs();
    inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hF; inst_addr = IA; inst_wdata = 0;
    data_wr = 1; data_size = 2'd2; data_wstrb = 4'h3; data_addr = DA; data_wdata = 32'h1234_5678;
    s_addr_ok_addr = 0; s_rdata = 0;
    data_req = 1; s_addr_ok = 1;
    #2;
    vecs++;
    if ({s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_unexp_rsp} !== 6'b0) begin
      errs++; $display("FAIL reset_outputs got %b want 000000",
        {s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_unexp_rsp});
    end
    step(); reset = 0; idle_inputs();
    $display("test_reset done");
  endtask

  task automatic test_inst_only();
    inst_req = 1; s_addr_ok = 1; s_addr_ok_addr = IA;
    @(negedge clk);
    vecs++;
    if ({s_req, inst_addr_ok, data_addr_ok} !== 3'b110) begin
      errs++; $display("FAIL inst_only_addr_ok got %b want 110", {s_req, inst_addr_ok, data_addr_ok});
    end
    vecs++;
    if (s_addr !== IA || inst_addr_ok_addr !== IA) begin
      errs++; $display("FAIL inst_only_addr got %h/%h want %h", s_addr, inst_addr_ok_addr, IA);
    end
    step(); inst_req = 0; s_addr_ok = 0;
    step(); s_data_ok = 1; s_rdata = 32'h3C1A_0000;
    @(negedge clk);
    vecs++;
    if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h3C1A_0000) begin
      errs++; $display("FAIL inst_only_rsp got %b %h want 10 3c1a0000", {inst_data_ok, data_data_ok}, inst_rdata);
    end
    step(); s_data_ok = 0;
    $display("test_inst_only done");
  endtask

  task automatic test_streak();
    logic [1:0]  exp_aok, exp_dok;
    logic [31:0] exp_addr;
    inst_req = 1; data_req = 1; s_addr_ok = 1;
    for (int k = 0; k < 6; k++) begin
      s_data_ok = (k > 0);
      exp_aok  = (k == 4) ? 2'b10 : 2'b01;
      exp_addr = (k == 4) ? IA : DA;
      exp_dok  = (k == 0) ? 2'b00 : (k == 5) ? 2'b10 : 2'b01;
      @(negedge clk);
      vecs++;
      if ({inst_addr_ok, data_addr_ok} !== exp_aok || s_addr !== exp_addr) begin
        errs++; $display("FAIL streak_grant[%0d] got %b %h want %b %h", k,
          {inst_addr_ok, data_addr_ok}, s_addr, exp_aok, exp_addr);
      end
      vecs++;
      if ({inst_data_ok, data_data_ok} !== exp_dok) begin
        errs++; $display("FAIL streak_rsp[%0d] got %b want %b", k, {inst_data_ok, data_data_ok}, exp_dok);
      end
      step();
    end
    idle_inputs(); s_data_ok = 1;
    @(negedge clk);
    vecs++;
    if ({inst_data_ok, data_data_ok} !== 2'b01) begin
      errs++; $display("FAIL streak_drain got %b want 01", {inst_data_ok, data_data_ok});
    end
    step(); s_data_ok = 0;
    $display("test_streak done");
  endtask

  task automatic test_lock();
    data_req = 1; s_addr_ok = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vecs++;
      if (s_addr !== DA || {s_req, data_addr_ok} !== 2'b10) begin
        errs++; $display("FAIL lock_d_wait[%0d] got %h %b want %h 10", k, s_addr, {s_req, data_addr_ok}, DA);
      end
      step();
    end
    inst_req = 1;
    @(negedge clk);
    vecs++;
    if (s_addr !== DA || inst_addr_ok !== 1'b0) begin
      errs++; $display("FAIL lock_d_hold got %h %b want %h 0", s_addr, inst_addr_ok, DA);
    end
    step(); s_addr_ok = 1;
    @(negedge clk);
    vecs++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
      errs++; $display("FAIL lock_d_release got %b want 01", {inst_addr_ok, data_addr_ok});
    end
    step(); data_req = 0; s_addr_ok = 0;
    @(negedge clk);
    vecs++;
    if (s_addr !== IA) begin
      errs++; $display("FAIL lock_i_grant got %h want %h", s_addr, IA);
    end
    step(); data_req = 1;
    @(negedge clk);
    vecs++;
    if (s_addr !== IA || {inst_addr_ok, data_addr_ok} !== 2'b00) begin
      errs++; $display("FAIL lock_i_hold got %h %b want %h 00", s_addr, {inst_addr_ok, data_addr_ok}, IA);
    end
    step(); s_addr_ok = 1;
    @(negedge clk);
    vecs++;
    if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
      errs++; $display("FAIL lock_i_release got %b want 10", {inst_addr_ok, data_addr_ok});
    end
    step(); idle_inputs(); s_data_ok = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vecs++;
      if ({inst_data_ok, data_data_ok} !== ((k == 0) ? 2'b01 : 2'b10)) begin
        errs++; $display("FAIL lock_drain[%0d] got %b want %b", k, {inst_data_ok, data_data_ok},
          (k == 0) ? 2'b01 : 2'b10);
      end
      step();
    end
    s_data_ok = 0;
    $display("test_lock done");
  endtask

  task automatic test_fifo_full();
    logic [3:0] drain_seq;
    drain_seq = 4'b1011;   // bit k = 1 means data response expected at drain step k (k=3 first)
    s_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      inst_req = (k % 2 == 0); data_req = (k % 2 == 1);
      @(negedge clk);
      vecs++;
      if ({s_req, inst_addr_ok, data_addr_ok} !== ((k % 2 == 0) ? 3'b110 : 3'b101)) begin
        errs++; $display("FAIL full_fill[%0d] got %b", k, {s_req, inst_addr_ok, data_addr_ok});
      end
      step();
    end
    inst_req = 0; data_req = 1;
    @(negedge clk);
    vecs++;
    if ({s_req, data_addr_ok} !== 2'b00) begin
      errs++; $display("FAIL full_block got %b want 00", {s_req, data_addr_ok});
    end
    step(); s_data_ok = 1;
    @(negedge clk);
    vecs++;
    if (s_req !== 1'b0 || {inst_data_ok, data_data_ok} !== 2'b10) begin
      errs++; $display("FAIL full_pop got %b %b want 0 10", s_req, {inst_data_ok, data_data_ok});
    end
    step(); s_data_ok = 0;
    @(negedge clk);
    vecs++;
    if ({s_req, data_addr_ok} !== 2'b11) begin
      errs++; $display("FAIL full_reopen got %b want 11", {s_req, data_addr_ok});
    end
    step(); idle_inputs(); s_data_ok = 1;
    for (int k = 3; k >= 0; k--) begin
      @(negedge clk);
      vecs++;
      if ({inst_data_ok, data_data_ok} !== (drain_seq[k] ? 2'b01 : 2'b10)) begin
        errs++; $display("FAIL full_order[%0d] got %b want %b", 3 - k, {inst_data_ok, data_data_ok},
          drain_seq[k] ? 2'b01 : 2'b10);
      end
      step();
    end
    s_data_ok = 0;
    $display("test_fifo_full done");
  endtask

  task automatic test_unexpected();
    s_data_ok = 1;
    @(negedge clk);
    vecs++;
    if ({inst_data_ok, data_data_ok, err_unexp_rsp} !== 3'b000) begin
      errs++; $display("FAIL unexp_rsp got %b want 000", {inst_data_ok, data_data_ok, err_unexp_rsp});
    end
    step(); s_data_ok = 0;
    @(negedge clk);
    vecs++;
    if (err_unexp_rsp !== 1'b1) begin
      errs++; $display("FAIL unexp_err got %b want 1", err_unexp_rsp);
    end
    step(); data_req = 1; s_addr_ok = 1; s_data_ok = 1;
    @(negedge clk);
    vecs++;
    if ({data_addr_ok, data_data_ok} !== 2'b10) begin
      errs++; $display("FAIL unexp_same_cycle got %b want 10", {data_addr_ok, data_data_ok});
    end
    step(); idle_inputs(); s_data_ok = 1;
    @(negedge clk);
    vecs++;
    if (data_data_ok !== 1'b1) begin
      errs++; $display("FAIL unexp_tag_kept got %b want 1", data_data_ok);
    end
    step(); s_data_ok = 0; step(); step();
    @(negedge clk);
    vecs++;
    if (err_unexp_rsp !== 1'b1) begin
      errs++; $display("FAIL unexp_sticky got %b want 1", err_unexp_rsp);
    end
    step();
    $display("test_unexpected done");
  endtask

  task automatic test_reset_mid();
    s_addr_ok = 1; inst_req = 1;
    step(); inst_req = 0; data_req = 1;
    step(); s_addr_ok = 0;
    step();                       // two tags outstanding, arbiter locked on data
    s_addr_ok = 1; s_data_ok = 1;
    #1 reset = 1;
    #1;
    vecs++;
    if ({s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_unexp_rsp} !== 6'b0) begin
      errs++; $display("FAIL reset_mid_outputs got %b want 000000",
        {s_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, err_unexp_rsp});
    end
    step(); reset = 0; idle_inputs(); s_data_ok = 1;
    @(negedge clk);
    vecs++;
    if ({inst_data_ok, data_data_ok} !== 2'b00) begin
      errs++; $display("FAIL reset_mid_empty got %b want 00", {inst_data_ok, data_data_ok});
    end
    step(); s_data_ok = 0; inst_req = 1; s_addr_ok = 1;
    @(negedge clk);
    vecs++;
    if (err_unexp_rsp !== 1'b1 || inst_addr_ok !== 1'b1 || s_addr !== IA) begin
      errs++; $display("FAIL reset_mid_idle got err=%b iaok=%b addr=%h want 1 1 %h",
        err_unexp_rsp, inst_addr_ok, s_addr, IA);
    end
    step(); idle_inputs();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_inst_only();
    test_streak();
    test_lock();
    test_fifo_full();
    test_unexpected();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
